dpb_frame_reader: RTL and testbench

DPB_FRAME_READER -- requirements
Module: dpb_frame_reader

---
 rtl/dsp_mem_pkg.sv | 32 +++
 rtl/dpb_skid_fifo.sv | 76 +++++++
 rtl/dpb_frame_reader.sv | 162 ++++++++++++++++
 tb/tb_dpb_frame_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mem_pkg.sv
// Shared constants for the DPB frame reader: default widths, FSM states and RAM read latency.
// Define DPB_RD_PIPE_EN to run the RAM output register (two-cycle read latency).
package dsp_mem_pkg;

   localparam int DPB_ADDR_W = 10;
   localparam int DPB_DATA_W = 32;

`ifdef DPB_RD_PIPE_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   // One slot per read that can be outstanding, plus one so a stalled beat never blocks the pipe.
   localparam int FIFO_DEPTH = RD_LAT + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } dpb_state_e;

   function automatic int unsigned count_ones(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/dpb_skid_fifo.sv
// First-word-fall-through FIFO: when empty, the write port is presented straight to the reader,
// so a word written and read in the same cycle never occupies a slot.
module dpb_skid_fifo
   import dsp_mem_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_flush,
   input  logic                           i_wr_en,
   input  logic [WIDTH-1:0]               i_wr_data,
   input  logic                           i_rd_en,
   output logic                           o_rd_valid,
   output logic [WIDTH-1:0]               o_rd_data,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [CNT_W-1:0] r_cnt;

   logic w_empty;
   logic w_push;
   logic w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign w_empty    = (r_cnt == '0);
   assign w_push     = i_wr_en && !(w_empty && i_rd_en);
   assign w_pop      = i_rd_en && !w_empty;
   assign o_rd_valid = !w_empty || i_wr_en;
   assign o_rd_data  = w_empty ? i_wr_data : r_mem[r_rp];
   assign o_count    = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wp <= ptr_inc(r_wp);
         end
         if (w_pop) begin
            r_rp <= ptr_inc(r_rp);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= i_wr_data;
      end
   end

endmodule

// File: rtl/dpb_frame_reader.sv
// Streams a frame of consecutive RAM words (address wraps mod 2^ADDR_W) onto a valid/ready port.
// Build option DPB_RD_PIPE_EN: use the RAM output register (ram_oce), read latency 2 instead of 1.
module dpb_frame_reader
   import dsp_mem_pkg::*;
#(
   parameter int ADDR_W = DPB_ADDR_W,
   parameter int DATA_W = DPB_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic              ram_reset,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

   dpb_state_e        r_state;
   dpb_state_e        w_state_nxt;
   logic [RD_LAT:0]   r_pipe;
   logic [ADDR_W-1:0] r_ad;
   logic [ADDR_W:0]   r_rd_left;
   logic [ADDR_W:0]   r_beat_left;
   logic              r_done;

   logic              w_accept;
   logic              w_zero_len;
   logic              w_issue;
   logic              w_abort;
   logic              w_frame_end;
   logic              w_hs;
   logic              w_fifo_valid;
   logic [DATA_W-1:0] w_fifo_data;
   logic [CNT_W-1:0]  w_fifo_cnt;
   logic [3:0]        w_total;

   // Words still owed to the stream once this cycle's handshake retires: FIFO plus every read in flight.
   assign w_hs    = w_fifo_valid && m_ready;
   assign w_total = 4'(w_fifo_cnt) + 4'(count_ones(8'(r_pipe))) - {3'd0, w_hs};

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_zero_len  = 1'b0;
      w_issue     = 1'b0;
      w_abort     = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               if (length != '0) begin
                  w_accept    = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_zero_len = 1'b1;
               end
            end
         end
         RUN: begin
            if (abort) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_issue = (r_rd_left != '0) && (w_total < 4'(FIFO_DEPTH));
               if ((r_rd_left == '0) || (w_issue && (r_rd_left == ONE))) begin
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_hs && (r_beat_left == ONE)) begin
               w_frame_end = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Read issue stage: r_pipe[0] is ram_ce, r_pipe[RD_LAT] marks ram_dout valid this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_pipe      <= '0;
         r_ad        <= '0;
         r_rd_left   <= '0;
         r_beat_left <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_zero_len || w_abort || w_frame_end;
         if (w_abort) begin
            r_pipe <= '0;
         end else begin
            r_pipe <= {r_pipe[RD_LAT-1:0], (w_accept || w_issue)};
         end
         if (w_accept) begin
            r_ad        <= base_addr;
            r_rd_left   <= length - ONE;
            r_beat_left <= length;
         end else begin
            if (w_issue) begin
               r_ad      <= r_ad + 1'b1;
               r_rd_left <= r_rd_left - ONE;
            end
            if (w_hs) begin
               r_beat_left <= r_beat_left - ONE;
            end
         end
      end
   end

   // Capture stage: RAM data lands in the FIFO RD_LAT cycles after its ram_ce.
   dpb_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_flush    (w_abort),
      .i_wr_en    (r_pipe[RD_LAT]),
      .i_wr_data  (ram_dout),
      .i_rd_en    (m_ready),
      .o_rd_valid (w_fifo_valid),
      .o_rd_data  (w_fifo_data),
      .o_count    (w_fifo_cnt)
   );

   assign ram_ce    = r_pipe[0];
   assign ram_ad    = r_ad;
   assign ram_reset = 1'b0;
   assign ram_wre   = 1'b0;
`ifdef DPB_RD_PIPE_EN
   assign ram_oce   = r_pipe[1];
`else
   assign ram_oce   = 1'b0;
`endif

   assign m_valid = w_fifo_valid;
   assign m_data  = w_fifo_valid ? w_fifo_data : '0;
   assign m_last  = w_fifo_valid && (r_beat_left == ONE);
   assign busy    = (r_state != IDLE);
   assign done    = r_done;

endmodule

// File: tb/tb_dpb_frame_reader.sv
// Bench for dpb_frame_reader: a RAM model preloaded with 0xA500_0000+i, a table of frames,
// and hand-written sequences for reset, start+abort in IDLE and start while busy.
module tb_dpb_frame_reader;

   localparam int AW = 10;
   localparam int DW = 32;
`ifdef DPB_RD_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          m_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          ram_ce, ram_oce, ram_reset, ram_wre;
   logic [AW-1:0] ram_ad;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] m_data;
   logic          m_valid, m_last, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] mem [1024];
   logic [AW-1:0] lat_ad = '0;
   logic [DW-1:0] oreg = '0;

   typedef struct {
      int base;
      int len;
      int rdy;
      int abort_at;
      bit spur;
      int exp_beats;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_ce) lat_ad <= ram_ad;
`ifdef DPB_RD_PIPE_EN
   always @(posedge clk) if (ram_oce) oreg <= mem[lat_ad];
   assign ram_dout = oreg;
`else
   assign ram_dout = mem[lat_ad];
`endif

   dpb_frame_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .abort     (abort),
      .ram_ce    (ram_ce),
      .ram_oce   (ram_oce),
      .ram_reset (ram_reset),
      .ram_wre   (ram_wre),
      .ram_ad    (ram_ad),
      .ram_dout  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_last    (m_last),
      .m_ready   (m_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] word_at(input int base, input int k);
      return 32'hA500_0000 + 32'((base + k) % 1024);
   endfunction

   task automatic chk_all_zero(input string nm);
      chk({nm, "_m_valid"}, 64'(m_valid), 0);
      chk({nm, "_m_last"},  64'(m_last),  0);
      chk({nm, "_m_data"},  64'(m_data),  0);
      chk({nm, "_done"},    64'(done),    0);
      chk({nm, "_busy"},    64'(busy),    0);
      chk({nm, "_ram_ce"},  64'(ram_ce),  0);
      chk({nm, "_ram_oce"}, 64'(ram_oce), 0);
      chk({nm, "_ram_ad"},  64'(ram_ad),  0);
   endtask

   task automatic run_frame(input vec_t v);
      int cyc = 0;
      int beats = 0;
      int ad_idx = 0;
      int done_cnt = 0;
      int done_cyc = -1;
      int first_cyc = -1;
      int last_cyc = -1;
      int ab_cyc = -1;
      bit held_v = 1'b0;
      bit busy_ok = 1'b1;
      bit leak = 1'b0;
      logic [DW-1:0] held_d = '0;
      @(negedge clk);
      base_addr = AW'(v.base);
      length    = (AW + 1)'(v.len);
      start     = 1'b1;
      while (cyc < 3000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
         @(negedge clk);
         cyc++;
         start = v.spur && (cyc == 3);
         if (v.spur && cyc == 3) base_addr = AW'(500);
         m_ready = ($urandom_range(0, 99) < v.rdy);
         abort = (v.abort_at >= 0) && (ab_cyc < 0) && (beats == v.abort_at);
         #1;
         if (ab_cyc >= 0 && cyc == ab_cyc + 1) begin
            chk("abort_m_valid", 64'(m_valid), 0);
            chk("abort_busy", 64'(busy), 0);
            chk("abort_done", 64'(done), 1);
         end
         if (ab_cyc >= 0 && cyc > ab_cyc && (ram_ce || m_valid)) leak = 1'b1;
         if ((m_valid || ram_ce) && !busy) busy_ok = 1'b0;
         if (ram_ce && !(ab_cyc >= 0 && cyc > ab_cyc)) begin
            chk("ram_ad", 64'(ram_ad), 64'((v.base + ad_idx) % 1024));
            ad_idx++;
         end
         if (held_v) begin
            chk("stall_valid", 64'(m_valid), 1);
            chk("stall_data", 64'(m_data), 64'(held_d));
         end
         if (m_valid && !(ab_cyc >= 0 && cyc > ab_cyc)) begin
            if (first_cyc < 0) first_cyc = cyc;
            chk("beat_data", 64'(m_data), 64'(word_at(v.base, beats)));
            chk("beat_last", 64'(m_last), 64'(beats == v.len - 1));
            if (m_ready) begin
               beats++;
               last_cyc = cyc;
               held_v = 1'b0;
            end else begin
               held_v = 1'b1;
               held_d = m_data;
            end
         end else begin
            held_v = 1'b0;
         end
         if (abort) begin
            ab_cyc = cyc;
            held_v = 1'b0;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            chk("done_busy", 64'(busy), 0);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      m_ready = 1'b0;
      chk("done_seen", 64'(done_cyc >= 0), 1);
      chk("done_count", 64'(done_cnt), 1);
      chk("beat_count", 64'(beats), 64'(v.exp_beats));
      chk("busy_cover", 64'(busy_ok), 1);
      chk("post_abort_quiet", 64'(leak), 0);
      if (v.abort_at < 0) chk("read_count", 64'(ad_idx), 64'(v.len));
      if (v.len > 0) chk("first_latency", 64'(first_cyc), 64'(LAT + 1));
      if (v.len > 0 && v.rdy >= 100 && v.abort_at < 0)
         chk("back_to_back", 64'(last_cyc - first_cyc), 64'(v.len - 1));
      if (v.len == 0)
         chk("done_time", 64'(done_cyc), 1);
      else if (v.abort_at >= 0)
         chk("done_time", 64'(done_cyc), 64'(ab_cyc + 1));
      else
         chk("done_time", 64'(done_cyc), 64'(last_cyc + 1));
   endtask

   initial begin
      int quiet;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);

      //            base  len  rdy abort spur beats
      vecs[0] = '{   0,    4, 100,  -1, 1'b0,   4};
      vecs[1] = '{1022,    4, 100,  -1, 1'b0,   4};
      vecs[2] = '{  37,   16,  30,  -1, 1'b0,  16};
      vecs[3] = '{  12,    0, 100,  -1, 1'b0,   0};
      vecs[4] = '{ 200,  100, 100,  11, 1'b0,  12};
      vecs[5] = '{   8,    2, 100,  -1, 1'b0,   2};
      vecs[6] = '{1020,    9,  50,  -1, 1'b1,   9};
      vecs[7] = '{   3,    1, 100,  -1, 1'b0,   1};

      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      chk("ram_wre", 64'(ram_wre), 0);
      chk("ram_reset", 64'(ram_reset), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 8; t++) run_frame(vecs[t]);

      // start and abort together in IDLE: start is dropped
      @(negedge clk);
      base_addr = AW'(4);
      length = (AW + 1)'(3);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      #1;
      chk("idle_abort_busy", 64'(busy), 0);
      chk("idle_abort_done", 64'(done), 0);
      quiet = 1;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (ram_ce || m_valid || done || busy) quiet = 0;
      end
      chk("idle_abort_quiet", 64'(quiet), 1);

      // reset in the middle of a stalled frame
      @(negedge clk);
      base_addr = AW'(0);
      length = (AW + 1)'(50);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_ready = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("pre_reset_valid", 64'(m_valid), 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done || busy || m_valid || ram_ce) quiet = 0;
      end
      chk("midreset_no_done", 64'(quiet), 1);
      run_frame('{10, 3, 100, -1, 1'b0, 3});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
